// File: rtl/instr_field_splitter.sv
// instr_field_splitter: flow-controlled one-stage splitter between fetch and
// the control decoder. Each word splits into opcode (top OP_W bits) and
// operand (low ARG_W bits). A prefix word (opcode == EXT_OP) contributes its
// argument as the upper half of the next word's double-width operand.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// PF_IDLE  | no prefix pending; the next plain word emits a zero upper half
// PF_HELD  | one prefix argument latched, waiting for its plain word
module instr_field_splitter #(
  parameter int               INSTR_W = 12,
  parameter int               OP_W    = 4,
  parameter logic [OP_W-1:0]  EXT_OP  = 4'hF
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [INSTR_W-1:0]             in_word,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [OP_W-1:0]                out_opcode,
  output logic [2*(INSTR_W-OP_W)-1:0]    out_operand,
  output logic                           out_ext,
  output logic                           err
);

  localparam int ARG_W = INSTR_W - OP_W;

  typedef enum logic {
    PF_IDLE = 1'b0,
    PF_HELD = 1'b1
  } pf_state_t;

  pf_state_t              r_pf_state;
  logic [ARG_W-1:0]       r_pf_arg;
  logic                   r_out_valid;
  logic [OP_W-1:0]        r_out_opcode;
  logic [2*ARG_W-1:0]     r_out_operand;
  logic                   r_out_ext;
  logic                   r_err;

  logic                   w_in_ready;
  logic                   w_accept;
  logic [OP_W-1:0]        w_op;
  logic [ARG_W-1:0]       w_arg;
  logic                   w_is_ext;
  logic [ARG_W-1:0]       w_upper;

  // Ready is a pure function of the output slot, never of in_valid or flush.
  assign w_in_ready = ~r_out_valid | out_ready;
  assign w_accept   = in_valid & w_in_ready;
  assign w_op       = in_word[INSTR_W-1:INSTR_W-OP_W];
  assign w_arg      = in_word[ARG_W-1:0];
  assign w_is_ext   = (w_op == EXT_OP);
  assign w_upper    = (r_pf_state == PF_HELD) ? r_pf_arg : '0;

  // Prefix FSM, output register and sticky error in one registered process.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pf_state    <= PF_IDLE;
      r_pf_arg      <= '0;
      r_out_valid   <= 1'b0;
      r_out_opcode  <= '0;
      r_out_operand <= '0;
      r_out_ext     <= 1'b0;
      r_err         <= 1'b0;
    end else if (flush) begin
      // Flush drops the held output, the pending prefix and any word
      // handshaken in the same cycle; data fields keep their last values.
      r_pf_state  <= PF_IDLE;
      r_out_valid <= 1'b0;
      r_err       <= 1'b0;
    end else if (w_accept) begin
      if (w_is_ext) begin
        // An accept with a held output implies it was consumed this edge,
        // so the slot empties: a prefix produces nothing downstream.
        r_pf_arg    <= w_arg;
        r_out_valid <= 1'b0;
        if (r_pf_state == PF_HELD) begin
          r_err <= 1'b1;
        end
        r_pf_state  <= PF_HELD;
      end else begin
        r_out_valid   <= 1'b1;
        r_out_opcode  <= w_op;
        r_out_operand <= {w_upper, w_arg};
        r_out_ext     <= (r_pf_state == PF_HELD);
        r_pf_state    <= PF_IDLE;
      end
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign in_ready    = w_in_ready;
  assign out_valid   = r_out_valid;
  assign out_opcode  = r_out_opcode;
  assign out_operand = r_out_operand;
  assign out_ext     = r_out_ext;
  assign err         = r_err;

endmodule

// File: tb/tb_instr_field_splitter.sv
// Testbench for instr_field_splitter: directed scenarios followed by a random
// stream, all compared against a transaction-level reference model.
module tb_instr_field_splitter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [11:0] in_word = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [3:0]  out_opcode;
  logic [15:0] out_operand;
  logic        out_ext;
  logic        err;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: one output slot plus an optional pending prefix.
  bit      m_full;
  int      m_op;
  int      m_operand;
  bit      m_ext;
  bit      m_pf;
  int      m_pf_arg;
  bit      m_err;

  instr_field_splitter dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_word(in_word),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_opcode(out_opcode), .out_operand(out_operand),
    .out_ext(out_ext), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_full = 0; m_op = 0; m_operand = 0; m_ext = 0;
    m_pf = 0; m_pf_arg = 0; m_err = 0;
  endtask

  // Drive one cycle's inputs, compare against the model, advance the model
  // across the coming rising edge, and return at the next falling edge.
  task automatic step(input bit v, input int w, input bit ordy, input bit fl);
    int  op, arg;
    bit  acc;
    in_valid = v; in_word = w[11:0]; out_ready = ordy; flush = fl;
    #1;
    chk("in_ready", {31'b0, in_ready}, {31'b0, (!m_full) | ordy});
    chk("out_valid", {31'b0, out_valid}, {31'b0, m_full});
    chk("err", {31'b0, err}, {31'b0, m_err});
    if (m_full) begin
      chk("opcode", {28'b0, out_opcode}, m_op);
      chk("operand", {16'b0, out_operand}, m_operand);
      chk("ext", {31'b0, out_ext}, {31'b0, m_ext});
    end
    op  = (w >> 8) & 'hF;
    arg = w & 'hFF;
    acc = v && (!m_full || ordy);
    if (fl) begin
      m_full = 0; m_pf = 0; m_err = 0;
    end else if (acc) begin
      if (op == 'hF) begin
        if (m_pf) m_err = 1;
        m_pf = 1; m_pf_arg = arg; m_full = 0;
      end else begin
        m_full = 1; m_op = op;
        m_operand = (m_pf ? m_pf_arg * 256 : 0) + arg;
        m_ext = m_pf; m_pf = 0;
      end
    end else if (m_full && ordy) begin
      m_full = 0;
    end
    @(negedge clk);
  endtask

  initial begin
    model_reset();
    #1;
    chk("rst_out_valid", {31'b0, out_valid}, 0);
    chk("rst_operand", {16'b0, out_operand}, 0);
    chk("rst_opcode", {28'b0, out_opcode}, 0);
    chk("rst_in_ready", {31'b0, in_ready}, 1);
    chk("rst_err", {31'b0, err}, 0);
    @(negedge clk);
    rst = 1'b0;

    // Plain word
    step(1, 'h3A5, 1, 0);
    chk("plain_valid", {31'b0, out_valid}, 1);
    chk("plain_opcode", {28'b0, out_opcode}, 3);
    chk("plain_operand", {16'b0, out_operand}, 'h0A5);
    chk("plain_ext", {31'b0, out_ext}, 0);
    step(0, 0, 1, 0);
    chk("plain_one_cycle", {31'b0, out_valid}, 0);

    // Prefix pair
    step(1, 'hF12, 1, 0);
    chk("pfx_no_out", {31'b0, out_valid}, 0);
    step(1, 'h7AB, 1, 0);
    chk("pfx_opcode", {28'b0, out_opcode}, 7);
    chk("pfx_operand", {16'b0, out_operand}, 'h12AB);
    chk("pfx_ext", {31'b0, out_ext}, 1);
    step(0, 0, 1, 0);

    // Backpressure
    step(1, 'h101, 1, 0);
    for (int i = 0; i < 3; i++) begin
      step(1, 'h202, 0, 0);
      chk("bp_hold_operand", {16'b0, out_operand}, 'h001);
      chk("bp_hold_opcode", {28'b0, out_opcode}, 1);
      chk("bp_in_ready", {31'b0, in_ready}, 0);
    end
    step(1, 'h202, 1, 0);
    chk("bp_second", {16'b0, out_operand}, 'h002);
    chk("bp_second_op", {28'b0, out_opcode}, 2);
    step(1, 'h303, 1, 0);
    chk("bp_third", {28'b0, out_opcode}, 3);
    step(0, 0, 1, 0);
    chk("bp_drained", {31'b0, out_valid}, 0);

    // Double prefix
    step(1, 'hF11, 1, 0);
    step(1, 'hF22, 1, 0);
    step(1, 'h5CC, 1, 0);
    chk("dbl_opcode", {28'b0, out_opcode}, 5);
    chk("dbl_operand", {16'b0, out_operand}, 'h22CC);
    chk("dbl_ext", {31'b0, out_ext}, 1);
    chk("dbl_err", {31'b0, err}, 1);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    chk("dbl_err_sticky", {31'b0, err}, 1);

    // Flush mid-prefix
    step(1, 'hF33, 1, 0);
    step(0, 0, 1, 1);
    chk("flush_err", {31'b0, err}, 0);
    step(1, 'h844, 1, 0);
    chk("flush_opcode", {28'b0, out_opcode}, 8);
    chk("flush_operand", {16'b0, out_operand}, 'h044);
    chk("flush_ext", {31'b0, out_ext}, 0);
    step(0, 0, 1, 0);

    // Async reset with a prefix held and err set
    step(1, 'hF11, 1, 0);
    step(1, 'hF22, 1, 0);
    in_valid = 0;
    #2 rst = 1'b1;
    #1;
    chk("arst_err", {31'b0, err}, 0);
    chk("arst_valid", {31'b0, out_valid}, 0);
    model_reset();
    #1 rst = 1'b0;
    @(negedge clk);
    step(1, 'h1FF, 1, 0);
    chk("arst_operand", {16'b0, out_operand}, 'h0FF);
    chk("arst_ext", {31'b0, out_ext}, 0);

    // Async reset with an output held under backpressure
    step(1, 'h2AA, 0, 0);
    step(0, 0, 0, 0);
    #2 rst = 1'b1;
    #1;
    chk("arst_held_valid", {31'b0, out_valid}, 0);
    chk("arst_held_ready", {31'b0, in_ready}, 1);
    model_reset();
    #1 rst = 1'b0;
    @(negedge clk);

    // Random stream
    for (int i = 0; i < 400; i++) begin
      int w;
      w = $urandom_range(0, 'hFFF);
      if ($urandom_range(0, 3) == 0) w = w | 'hF00;
      step($urandom_range(0, 3) != 0, w, $urandom_range(0, 2) != 0,
           $urandom_range(0, 24) == 0);
    end
    step(0, 0, 1, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
